// File: rtl/phy_regfile_ckpt.sv
// Physical register file with per-register valid bits, writeback bypass and
// valid-vector checkpoints that stay current with writebacks issued after the save.
module phy_regfile_ckpt #(
   parameter int PHY_REG_NUM    = 64,
   parameter int REG_DATA_WIDTH = 32,
   parameter int ARCH_REG_NUM   = 32,
   parameter int READ_PORTS     = 4,
   parameter int WB_PORTS       = 2,
   parameter int INV_PORTS      = 2,
   parameter int CKPT_NUM       = 4,
   parameter int BYPASS         = 1,
   localparam int ID_W  = (PHY_REG_NUM > 1) ? $clog2(PHY_REG_NUM) : 1,
   localparam int CK_W  = (CKPT_NUM > 1) ? $clog2(CKPT_NUM) : 1,
   localparam int CNT_W = $clog2(PHY_REG_NUM + 1)
) (
   input  logic                                         clk,
   input  logic                                         rst,
   input  logic [READ_PORTS-1:0][ID_W-1:0]              rd_id,
   output logic [READ_PORTS-1:0][REG_DATA_WIDTH-1:0]    rd_data,
   output logic [READ_PORTS-1:0]                        rd_valid,
   input  logic [WB_PORTS-1:0][ID_W-1:0]                wb_id,
   input  logic [WB_PORTS-1:0][REG_DATA_WIDTH-1:0]      wb_data,
   input  logic [WB_PORTS-1:0]                          wb_we,
   input  logic [INV_PORTS-1:0][ID_W-1:0]               inv_id,
   input  logic [INV_PORTS-1:0]                         inv_en,
   input  logic                                         ckpt_save,
   input  logic [CK_W-1:0]                              ckpt_save_id,
   input  logic                                         ckpt_restore,
   input  logic [CK_W-1:0]                              ckpt_restore_id,
   output logic [CNT_W-1:0]                             valid_count
);

   logic [REG_DATA_WIDTH-1:0] data_q [PHY_REG_NUM];
   logic [REG_DATA_WIDTH-1:0] data_d [PHY_REG_NUM];
   logic [PHY_REG_NUM-1:0]    valid_q, valid_d;
   logic [PHY_REG_NUM-1:0]    slot_q [CKPT_NUM];
   logic [PHY_REG_NUM-1:0]    slot_d [CKPT_NUM];
   logic [PHY_REG_NUM-1:0]    reset_vec;
   logic [PHY_REG_NUM-1:0]    wb_set, inv_clr;

   function automatic logic id_ok(input logic [ID_W-1:0] id);
      return 32'(id) < PHY_REG_NUM;
   endfunction

   function automatic logic ck_ok(input logic [CK_W-1:0] id);
      return 32'(id) < CKPT_NUM;
   endfunction

   always_comb begin
      reset_vec = '0;
      for (int i = 1; i < PHY_REG_NUM; i++) begin
         reset_vec[i] = (i < ARCH_REG_NUM);
      end
   end

   // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
   // Ports are walked high-to-low so the lowest-index writer ends up owning a register.
   always_comb begin
      data_d  = data_q;
      wb_set  = '0;
      inv_clr = '0;
      for (int p = WB_PORTS - 1; p >= 0; p--) begin
         if (wb_we[p] && id_ok(wb_id[p])) begin
            data_d[wb_id[p]] = wb_data[p];
            wb_set[wb_id[p]] = 1'b1;
         end
      end
      for (int p = 0; p < INV_PORTS; p++) begin
         if (inv_en[p] && id_ok(inv_id[p])) begin
            inv_clr[inv_id[p]] = 1'b1;
         end
      end
   end

   // Restore outranks writeback outranks invalidation; writebacks still land on top of a restore.
   always_comb begin
      valid_d = (valid_q & ~inv_clr) | wb_set;
      if (ckpt_restore && ck_ok(ckpt_restore_id)) begin
         valid_d = slot_q[ckpt_restore_id] | wb_set;
      end
      for (int s = 0; s < CKPT_NUM; s++) begin
         slot_d[s] = slot_q[s] | wb_set;
         if (ckpt_save && ck_ok(ckpt_save_id) && (CK_W'(s) == ckpt_save_id)) begin
            slot_d[s] = valid_d;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
   // NOTE: the data array is reset on purpose: software-visible registers must read zero after reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         data_q  <= '{default: '0};
         valid_q <= reset_vec;
         slot_q  <= '{default: reset_vec};
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
         slot_q  <= slot_d;
      end
   end

   always_comb begin
      for (int r = 0; r < READ_PORTS; r++) begin
         rd_data[r]  = '0;
         rd_valid[r] = 1'b0;
         if (id_ok(rd_id[r])) begin
            rd_data[r]  = data_q[rd_id[r]];
            rd_valid[r] = valid_q[rd_id[r]];
            if (BYPASS != 0) begin
               for (int p = WB_PORTS - 1; p >= 0; p--) begin
                  if (wb_we[p] && (wb_id[p] == rd_id[r])) begin
                     rd_data[r]  = wb_data[p];
                     rd_valid[r] = 1'b1;
                  end
               end
            end
         end
      end
   end

   always_comb begin
      valid_count = '0;
      for (int i = 0; i < PHY_REG_NUM; i++) begin
         valid_count = valid_count + CNT_W'(valid_q[i]);
      end
   end

endmodule

// File: tb/tb_phy_regfile_ckpt.sv
// Directed bench for phy_regfile_ckpt: table of read/writeback/invalidate vectors
// followed by hand-written checkpoint and reset sequences.
module tb_phy_regfile_ckpt;

   logic                   clk = 1'b0;
   logic                   rst;
   logic [3:0][5:0]        rd_id;
   logic [3:0][31:0]       rd_data;
   logic [3:0]             rd_valid;
   logic [1:0][5:0]        wb_id;
   logic [1:0][31:0]       wb_data;
   logic [1:0]             wb_we;
   logic [1:0][5:0]        inv_id;
   logic [1:0]             inv_en;
   logic                   ckpt_save;
   logic [1:0]             ckpt_save_id;
   logic                   ckpt_restore;
   logic [1:0]             ckpt_restore_id;
   logic [6:0]             valid_count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   phy_regfile_ckpt dut (
      .clk(clk), .rst(rst),
      .rd_id(rd_id), .rd_data(rd_data), .rd_valid(rd_valid),
      .wb_id(wb_id), .wb_data(wb_data), .wb_we(wb_we),
      .inv_id(inv_id), .inv_en(inv_en),
      .ckpt_save(ckpt_save), .ckpt_save_id(ckpt_save_id),
      .ckpt_restore(ckpt_restore), .ckpt_restore_id(ckpt_restore_id),
      .valid_count(valid_count)
   );

   typedef struct {
      logic        we0;  logic [5:0] id0;  logic [31:0] d0;
      logic        we1;  logic [5:0] id1;  logic [31:0] d1;
      logic        inv0; logic [5:0] iid0;
      logic [5:0]  r0;   logic       ev0;  logic [31:0] ed0;
      logic [5:0]  r1;   logic       ev1;  logic [31:0] ed1;
      logic [6:0]  cnt;
   } vec_t;

   vec_t tbl [10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic idle();
      wb_we = '0; wb_id = '0; wb_data = '0;
      inv_en = '0; inv_id = '0;
      ckpt_save = 1'b0; ckpt_save_id = '0;
      ckpt_restore = 1'b0; ckpt_restore_id = '0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      idle();
   endtask

   task automatic rd_chk(input string name, input logic [5:0] id, input logic ev, input logic [31:0] ed);
      rd_id[0] = id;
      #1;
      check({name, "_valid"}, 32'(rd_valid[0]), 32'(ev));
      check({name, "_data"}, rd_data[0], ed);
   endtask

   initial begin
      tbl[0] = '{1'b0, 6'd0,  32'h0,        1'b0, 6'd0,  32'h0,    1'b0, 6'd0,  6'd5,  1'b1, 32'h0,        6'd40, 1'b0, 32'h0,    7'd31};
      tbl[1] = '{1'b1, 6'd40, 32'hDEADBEEF, 1'b0, 6'd0,  32'h0,    1'b0, 6'd0,  6'd40, 1'b1, 32'hDEADBEEF, 6'd41, 1'b0, 32'h0,    7'd32};
      tbl[2] = '{1'b1, 6'd41, 32'h1111,     1'b1, 6'd41, 32'h2222, 1'b0, 6'd0,  6'd40, 1'b1, 32'hDEADBEEF, 6'd41, 1'b1, 32'h1111, 7'd33};
      tbl[3] = '{1'b0, 6'd0,  32'h0,        1'b0, 6'd0,  32'h0,    1'b0, 6'd0,  6'd41, 1'b1, 32'h1111,     6'd0,  1'b0, 32'h0,    7'd33};
      tbl[4] = '{1'b0, 6'd0,  32'h0,        1'b1, 6'd42, 32'h4242, 1'b1, 6'd42, 6'd42, 1'b1, 32'h4242,     6'd42, 1'b1, 32'h4242, 7'd34};
      tbl[5] = '{1'b0, 6'd0,  32'h0,        1'b0, 6'd0,  32'h0,    1'b1, 6'd42, 6'd42, 1'b1, 32'h4242,     6'd40, 1'b1, 32'hDEADBEEF, 7'd33};
      tbl[6] = '{1'b0, 6'd0,  32'h0,        1'b0, 6'd0,  32'h0,    1'b0, 6'd0,  6'd42, 1'b0, 32'h4242,     6'd31, 1'b1, 32'h0,    7'd33};
      tbl[7] = '{1'b0, 6'd0,  32'h0,        1'b0, 6'd0,  32'h0,    1'b1, 6'd5,  6'd5,  1'b1, 32'h0,        6'd63, 1'b0, 32'h0,    7'd32};
      tbl[8] = '{1'b1, 6'd5,  32'h55,       1'b0, 6'd0,  32'h0,    1'b1, 6'd5,  6'd5,  1'b1, 32'h55,       6'd42, 1'b0, 32'h4242, 7'd33};
      tbl[9] = '{1'b1, 6'd0,  32'hA,        1'b0, 6'd0,  32'h0,    1'b0, 6'd0,  6'd0,  1'b1, 32'hA,        6'd5,  1'b1, 32'h55,   7'd34};

      rst = 1'b1;
      idle();
      rd_id = '{6'd3, 6'd2, 6'd40, 6'd5};
      repeat (2) @(posedge clk);
      #1;
      check("reset_count_in_rst", 32'(valid_count), 32'd31);
      rst = 1'b0;

      for (int i = 0; i < 10; i++) begin
         wb_we   = {tbl[i].we1, tbl[i].we0};
         wb_id   = {tbl[i].id1, tbl[i].id0};
         wb_data = {tbl[i].d1, tbl[i].d0};
         inv_en  = {1'b0, tbl[i].inv0};
         inv_id  = {6'd0, tbl[i].iid0};
         rd_id[0] = tbl[i].r0;
         rd_id[1] = tbl[i].r1;
         #1;
         check($sformatf("v%0d_rv0", i), 32'(rd_valid[0]), 32'(tbl[i].ev0));
         check($sformatf("v%0d_rd0", i), rd_data[0], tbl[i].ed0);
         check($sformatf("v%0d_rv1", i), 32'(rd_valid[1]), 32'(tbl[i].ev1));
         check($sformatf("v%0d_rd1", i), rd_data[1], tbl[i].ed1);
         step();
         check($sformatf("v%0d_count", i), 32'(valid_count), 32'(tbl[i].cnt));
      end

      // Checkpoint sequence: live = regs 0..31, 40, 41 (34 bits).
      ckpt_save = 1'b1; ckpt_save_id = 2'd2;
      step();
      inv_en[0] = 1'b1; inv_id[0] = 6'd5;
      step();
      check("ck_inv5_count", 32'(valid_count), 32'd33);
      wb_we[0] = 1'b1; wb_id[0] = 6'd50; wb_data[0] = 32'h5050;
      step();
      check("ck_wb50_count", 32'(valid_count), 32'd34);
      ckpt_restore = 1'b1; ckpt_restore_id = 2'd2;
      step();
      check("ck_restore2_count", 32'(valid_count), 32'd35);
      rd_chk("ck_restore2_r5", 6'd5, 1'b1, 32'h55);
      rd_chk("ck_restore2_r50", 6'd50, 1'b1, 32'h5050);

      // Slot 3 was never saved: reset vector plus every writeback since reset.
      ckpt_restore = 1'b1; ckpt_restore_id = 2'd3;
      step();
      check("ck_restore3_count", 32'(valid_count), 32'd36);
      rd_chk("ck_restore3_r42", 6'd42, 1'b1, 32'h4242);
      inv_en[1] = 1'b1; inv_id[1] = 6'd42;
      step();
      check("ck_inv42_count", 32'(valid_count), 32'd35);

      // Save and restore the same slot with a concurrent writeback.
      ckpt_save = 1'b1; ckpt_save_id = 2'd0;
      ckpt_restore = 1'b1; ckpt_restore_id = 2'd0;
      wb_we[1] = 1'b1; wb_id[1] = 6'd60; wb_data[1] = 32'h6060;
      step();
      check("ck_same_slot_count", 32'(valid_count), 32'd37);
      inv_en = 2'b11; inv_id = {6'd60, 6'd60};
      step();
      check("ck_inv60_count", 32'(valid_count), 32'd36);
      ckpt_restore = 1'b1; ckpt_restore_id = 2'd0;
      step();
      check("ck_restore0_count", 32'(valid_count), 32'd37);
      rd_chk("ck_restore0_r42", 6'd42, 1'b1, 32'h4242);
      rd_chk("ck_restore0_r60", 6'd60, 1'b1, 32'h6060);

      // Reset overrides a same-cycle writeback and save.
      rst = 1'b1;
      wb_we[0] = 1'b1; wb_id[0] = 6'd40; wb_data[0] = 32'h9999;
      ckpt_save = 1'b1; ckpt_save_id = 2'd1;
      step();
      rst = 1'b0;
      check("rst_count", 32'(valid_count), 32'd31);
      rd_chk("rst_r40", 6'd40, 1'b0, 32'h0);
      rd_chk("rst_r0", 6'd0, 1'b0, 32'h0);
      rd_chk("rst_r5", 6'd5, 1'b1, 32'h0);
      ckpt_restore = 1'b1; ckpt_restore_id = 2'd1;
      step();
      check("rst_restore1_count", 32'(valid_count), 32'd31);
      rd_chk("rst_restore1_r40", 6'd40, 1'b0, 32'h0);
      ckpt_restore = 1'b1; ckpt_restore_id = 2'd0;
      step();
      check("rst_restore0_count", 32'(valid_count), 32'd31);
      rd_chk("rst_restore0_r60", 6'd60, 1'b0, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
